// File: rtl/ifetch_prefetch_pkg.sv
// Shared types and default parameters for the instruction prefetch front end.
package ifetch_prefetch_pkg;

  localparam int INST_ADDR_WIDTH_DEF = 10;
  localparam int INST_DATA_WIDTH_DEF = 32;
  localparam int IF_DEPTH_DEF        = 4;
  localparam int RESET_PC_DEF        = 0;
  localparam int PC_STEP_DEF         = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } if_state_t;

  // Queue entry layout at the default widths; the fetcher re-declares the
  // same layout at its own parameterised widths.
  typedef struct packed {
    logic [INST_ADDR_WIDTH_DEF-1:0] pc;
    logic [INST_DATA_WIDTH_DEF-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Fetcher bus: imem read port, decode handshake, redirect and occupancy.
interface ifetch_prefetch_if
  import ifetch_prefetch_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = INST_ADDR_WIDTH_DEF,
  parameter int INST_DATA_WIDTH = INST_DATA_WIDTH_DEF,
  parameter int IF_DEPTH        = IF_DEPTH_DEF
);
  localparam int CW = $clog2(IF_DEPTH) + 1;

  logic                       start;
  logic                       imem_en;
  logic [INST_ADDR_WIDTH-1:0] imem_addr;
  logic [INST_DATA_WIDTH-1:0] imem_data;
  logic                       if_valid;
  logic                       if_ready;
  logic [INST_DATA_WIDTH-1:0] if_inst;
  logic [INST_ADDR_WIDTH-1:0] if_pc;
  logic                       redirect_valid;
  logic [INST_ADDR_WIDTH-1:0] redirect_pc;
  logic [CW-1:0]              fifo_count;

  modport master (
    input  start, imem_data, if_ready, redirect_valid, redirect_pc,
    output imem_en, imem_addr, if_valid, if_inst, if_pc, fifo_count
  );

  modport slave (
    output start, imem_data, if_ready, redirect_valid, redirect_pc,
    input  imem_en, imem_addr, if_valid, if_inst, if_pc, fifo_count
  );

endinterface

// File: rtl/ifetch_prefetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries; flush wins over push/pop.
module ifetch_prefetch_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage; cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/ifetch_prefetch.sv
// Pipelined instruction fetcher: issues sequential imem reads against a credit
// limit and queues {pc, inst} for decode; redirect flushes the queue.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = INST_ADDR_WIDTH_DEF,
  parameter int INST_DATA_WIDTH = INST_DATA_WIDTH_DEF,
  parameter int IF_DEPTH        = IF_DEPTH_DEF,
  parameter int RESET_PC        = RESET_PC_DEF,
  parameter int PC_STEP         = PC_STEP_DEF
) (
  input logic                clk,
  input logic                rst,
  ifetch_prefetch_if.master  bus
);
  localparam int CW = $clog2(IF_DEPTH) + 1;
  localparam logic [CW:0]                DEPTH_V = (CW+1)'(IF_DEPTH);
  localparam logic [INST_ADDR_WIDTH-1:0] STEP_V  = INST_ADDR_WIDTH'(PC_STEP);
  localparam logic [INST_ADDR_WIDTH-1:0] START_V = INST_ADDR_WIDTH'(RESET_PC);

  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic [INST_DATA_WIDTH-1:0] inst;
  } entry_t;
  localparam int EW = $bits(entry_t);

  if_state_t                  state_q;
  if_state_t                  state_d;
  logic [INST_ADDR_WIDTH-1:0] fetch_pc_p0;
  logic [INST_ADDR_WIDTH-1:0] pc_p1;
  logic                       vld_p1;
  logic                       issue;
  logic                       push;
  logic                       pop;
  logic                       kill;
  logic                       full;
  logic                       empty;
  logic [CW-1:0]              count;
  logic [CW:0]                credit_used;
  entry_t                     push_entry;
  entry_t                     head_entry;

  // A redirect kills the response landing this cycle and hides the head.
  assign kill        = bus.redirect_valid;
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, vld_p1};
  assign pop         = bus.if_valid && bus.if_ready;
  assign push        = vld_p1 && !kill;
  assign push_entry  = '{pc: pc_p1, inst: bus.imem_data};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and issue decision; a pop frees a slot in the same cycle.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (bus.start && !bus.redirect_valid) state_d = RUN;
      RUN:  issue = !bus.redirect_valid && ((credit_used < DEPTH_V) || pop);
      default: state_d = IDLE;
    endcase
  end

  // Fetch PC: redirect beats start beats sequential advance.
  always_ff @(posedge clk) begin
    if (rst)                              fetch_pc_p0 <= '0;
    else if (bus.redirect_valid)          fetch_pc_p0 <= bus.redirect_pc;
    else if (state_q == IDLE && bus.start) fetch_pc_p0 <= START_V;
    else if (issue)                       fetch_pc_p0 <= fetch_pc_p0 + STEP_V;
  end

  // ---- p0 -> p1: read issued, response due next cycle ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= issue;
  end

  // PC tag travelling with the outstanding read.
  always_ff @(posedge clk) begin
    pc_p1 <= fetch_pc_p0;
  end

  // ---- p1 -> queue: response written unless killed ----
  ifetch_prefetch_fifo #(
    .W     (EW),
    .DEPTH (IF_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (kill),
    .din   (push_entry),
    .dout  (head_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Credit accounting must never let a response arrive at a full queue.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !pop));
  end

  assign bus.imem_en    = issue;
  assign bus.imem_addr  = fetch_pc_p0;
  assign bus.if_valid   = !empty && !bus.redirect_valid;
  assign bus.if_inst    = head_entry.inst;
  assign bus.if_pc      = head_entry.pc;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: default build plus a 4-bit-address build
// for PC wrap.
module tb_ifetch_prefetch;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  ifetch_prefetch_if #(.INST_ADDR_WIDTH(10), .INST_DATA_WIDTH(32), .IF_DEPTH(4)) bus ();
  ifetch_prefetch_if #(.INST_ADDR_WIDTH(4),  .INST_DATA_WIDTH(32), .IF_DEPTH(4)) wbus ();

  ifetch_prefetch #(
    .INST_ADDR_WIDTH(10), .INST_DATA_WIDTH(32), .IF_DEPTH(4), .RESET_PC(0), .PC_STEP(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ifetch_prefetch #(
    .INST_ADDR_WIDTH(4), .INST_DATA_WIDTH(32), .IF_DEPTH(4), .RESET_PC(14), .PC_STEP(1)
  ) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory models: word at addr is 0xA0000000 + addr, one-cycle latency.
  always @(posedge clk) if (bus.imem_en)  bus.imem_data  <= 32'hA000_0000 + 32'(bus.imem_addr);
  always @(posedge clk) if (wbus.imem_en) wbus.imem_data <= 32'hA000_0000 + 32'(wbus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus.start = 1'b0; bus.if_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    wbus.start = 1'b0; wbus.if_ready = 1'b0; wbus.redirect_valid = 1'b0; wbus.redirect_pc = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for if_valid on the main bus; returns at the negedge it is seen.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mid();
      if (bus.if_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic start_pulse(input logic ready);
    tick();
    bus.if_ready = ready;
    bus.start = 1'b1;
    mid();
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.if_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    wbus.start = 1'b0; wbus.if_ready = 1'b0; wbus.redirect_valid = 1'b0; wbus.redirect_pc = '0;
    tick();
    tick();
    mid();
    n_total++;
    if ({bus.imem_en, bus.imem_addr, bus.if_valid, bus.if_inst, bus.if_pc, bus.fifo_count} !==
        {1'b0, 10'h0, 1'b0, 32'h0, 10'h0, 3'd0})
      $display("FAIL reset_outputs: got en=%b addr=%h v=%b inst=%h pc=%h cnt=%0d want all zero",
               bus.imem_en, bus.imem_addr, bus.if_valid, bus.if_inst, bus.if_pc, bus.fifo_count);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      mid();
    end
    n_total++;
    if (bus.imem_en !== 1'b0) $display("FAIL idle_no_fetch: got imem_en=%b want 0", bus.imem_en);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    tick();
    bus.if_ready = 1'b1;
    bus.start = 1'b1;
    mid();
    n_total++;
    if (bus.imem_en !== 1'b0) $display("FAIL stream_en_t0: got %b want 0", bus.imem_en);
    else n_pass++;
    tick();
    bus.start = 1'b0;
    mid();
    n_total++;
    if ({bus.imem_en, bus.imem_addr, bus.if_valid} !== {1'b1, 10'h000, 1'b0})
      $display("FAIL stream_en_t1: got en=%b addr=%h v=%b want en=1 addr=000 v=0",
               bus.imem_en, bus.imem_addr, bus.if_valid);
    else n_pass++;
    tick();
    mid();
    n_total++;
    if (bus.if_valid !== 1'b0) $display("FAIL stream_valid_t2: got %b want 0", bus.if_valid);
    else n_pass++;
    tick();
    mid();
    n_total++;
    if ({bus.if_valid, bus.if_pc, bus.if_inst} !== {1'b1, 10'h000, 32'hA000_0000})
      $display("FAIL stream_first: got v=%b pc=%h inst=%h want v=1 pc=000 inst=a0000000",
               bus.if_valid, bus.if_pc, bus.if_inst);
    else n_pass++;
    // A start pulse while running must not restart the stream.
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.start = (k == 2);
      mid();
      n_total++;
      if ({bus.if_valid, bus.if_pc, bus.if_inst} !== {1'b1, 10'(k), 32'hA000_0000 + 32'(k)})
        $display("FAIL stream_seq%0d: got v=%b pc=%h inst=%h want v=1 pc=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, 10'(k));
      else n_pass++;
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_backpressure();
    int n_iss;
    do_reset();
    start_pulse(1'b0);
    n_iss = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (bus.imem_en) n_iss++;
      tick();
    end
    n_total++;
    if (n_iss !== 4) $display("FAIL bp_issue_count: got %0d want 4", n_iss);
    else n_pass++;
    mid();
    n_total++;
    if ({bus.imem_en, bus.fifo_count} !== {1'b0, 3'd4})
      $display("FAIL bp_full: got en=%b cnt=%0d want en=0 cnt=4", bus.imem_en, bus.fifo_count);
    else n_pass++;
    bus.if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if ({bus.if_valid, bus.if_pc} !== {1'b1, 10'(i)})
        $display("FAIL bp_drain%0d: got v=%b pc=%h want v=1 pc=%h", i, bus.if_valid, bus.if_pc, 10'(i));
      else n_pass++;
      tick();
      mid();
    end
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset();
    start_pulse(1'b0);
    mid();
    tick();
    mid();
    tick();
    mid();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h100;
    mid();
    n_total++;
    if ({bus.fifo_count, bus.if_valid, bus.imem_en} !== {3'd2, 1'b0, 1'b0})
      $display("FAIL redir_cycle: got cnt=%0d v=%b en=%b want cnt=2 v=0 en=0",
               bus.fifo_count, bus.if_valid, bus.imem_en);
    else n_pass++;
    tick();
    bus.redirect_valid = 1'b0;
    bus.if_ready = 1'b1;
    mid();
    n_total++;
    if ({bus.fifo_count, bus.imem_en, bus.imem_addr} !== {3'd0, 1'b1, 10'h100})
      $display("FAIL redir_after: got cnt=%0d en=%b addr=%h want cnt=0 en=1 addr=100",
               bus.fifo_count, bus.imem_en, bus.imem_addr);
    else n_pass++;
    wait_valid(ok);
    n_total++;
    if (!ok || {bus.if_pc, bus.if_inst} !== {10'h100, 32'hA000_0100})
      $display("FAIL redir_first: got ok=%b pc=%h inst=%h want pc=100 inst=a0000100",
               ok, bus.if_pc, bus.if_inst);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [3:0] got [4];
    logic [3:0] exp_pc [4];
    int n;
    exp_pc[0] = 4'hE; exp_pc[1] = 4'hF; exp_pc[2] = 4'h0; exp_pc[3] = 4'h1;
    do_reset();
    tick();
    wbus.if_ready = 1'b1;
    wbus.start = 1'b1;
    tick();
    wbus.start = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      mid();
      if (wbus.if_valid && n < 4) begin
        got[n] = wbus.if_pc;
        n++;
      end
      tick();
    end
    n_total++;
    if (n !== 4) $display("FAIL wrap_count: got %0d want 4", n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        n_total++;
        if (got[i] !== exp_pc[i]) $display("FAIL wrap_pc%0d: got %h want %h", i, got[i], exp_pc[i]);
        else n_pass++;
      end
    end
    wbus.if_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int n_en;
    do_reset();
    start_pulse(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (bus.fifo_count == 3'd3) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_total++;
    if (!seen) $display("FAIL rstmid_fill: got cnt=%0d want 3", bus.fifo_count);
    else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    n_total++;
    if ({bus.imem_en, bus.imem_addr, bus.if_valid, bus.if_inst, bus.if_pc, bus.fifo_count} !==
        {1'b0, 10'h0, 1'b0, 32'h0, 10'h0, 3'd0})
      $display("FAIL rstmid_outputs: got en=%b addr=%h v=%b inst=%h pc=%h cnt=%0d want all zero",
               bus.imem_en, bus.imem_addr, bus.if_valid, bus.if_inst, bus.if_pc, bus.fifo_count);
    else n_pass++;
    n_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      mid();
      if (bus.imem_en) n_en++;
    end
    n_total++;
    if (n_en !== 0) $display("FAIL rstmid_quiet: got %0d fetches want 0", n_en);
    else n_pass++;
    start_pulse(1'b1);
    wait_valid(ok);
    n_total++;
    if (!ok || {bus.if_pc, bus.if_inst} !== {10'h000, 32'hA000_0000})
      $display("FAIL rstmid_restart: got ok=%b pc=%h inst=%h want pc=000", ok, bus.if_pc, bus.if_inst);
    else n_pass++;
  endtask

  task automatic test_redirect_pop();
    bit ok;
    do_reset();
    start_pulse(1'b1);
    for (int i = 0; i < 4; i++) begin
      mid();
      tick();
    end
    mid();
    n_total++;
    if ({bus.if_valid, bus.imem_en} !== 2'b11)
      $display("FAIL rp_pre: got v=%b en=%b want 1 1", bus.if_valid, bus.imem_en);
    else n_pass++;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h200;
    mid();
    n_total++;
    if ({bus.if_valid, bus.imem_en} !== 2'b00)
      $display("FAIL rp_cycle: got v=%b en=%b want 0 0", bus.if_valid, bus.imem_en);
    else n_pass++;
    tick();
    bus.redirect_valid = 1'b0;
    mid();
    n_total++;
    if (bus.fifo_count !== 3'd0) $display("FAIL rp_flushed: got cnt=%0d want 0", bus.fifo_count);
    else n_pass++;
    wait_valid(ok);
    n_total++;
    if (!ok || bus.if_pc !== 10'h200) $display("FAIL rp_first: got ok=%b pc=%h want 200", ok, bus.if_pc);
    else n_pass++;
    tick();
    mid();
    n_total++;
    if ({bus.if_valid, bus.if_pc} !== {1'b1, 10'h201})
      $display("FAIL rp_second: got v=%b pc=%h want v=1 pc=201", bus.if_valid, bus.if_pc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h300;
    tick();
    bus.redirect_pc = 10'h310;
    tick();
    bus.redirect_valid = 1'b0;
    wait_valid(ok);
    n_total++;
    if (!ok || {bus.if_pc, bus.if_inst} !== {10'h310, 32'hA000_0310})
      $display("FAIL b2b_redirect: got ok=%b pc=%h inst=%h want pc=310", ok, bus.if_pc, bus.if_inst);
    else n_pass++;
  endtask

  task automatic test_idle_redirect();
    bit ok;
    do_reset();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h055;
    tick();
    bus.redirect_valid = 1'b0;
    start_pulse(1'b1);
    wait_valid(ok);
    n_total++;
    if (!ok || bus.if_pc !== 10'h000) $display("FAIL idle_redirect: got ok=%b pc=%h want 000", ok, bus.if_pc);
    else n_pass++;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_redirect_pop();
    test_back_to_back();
    test_idle_redirect();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
